sm4_key_expand: RTL and testbench



---
 rtl/sm4_pkg.sv | 22 ++
 rtl/ck.sv | 29 ++
 rtl/sm4_sbox.sv | 28 ++
 rtl/sm4_tprime.sv | 20 ++
 rtl/sm4_key_expand.sv | 162 ++++++++++++++++
 tb/tb_sm4_key_expand.sv | 372 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FK constants, round count, FSM encoding, rotate helper.
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // 32-bit rotate left; n = 0 returns x unchanged.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/ck.sv
// SM4 CK constant ROM: CK[i] byte j = (4i + j) * 7 mod 256, one-cycle registered latency.
module ck (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  count,
    output logic [31:0] cki_out
);

    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  base;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            base = {1'b0, i, 2'b00} + 8'(j);
            w[31 - 8*j -: 8] = base * 8'd7;
        end
        return w;
    endfunction

    // Registered constant lookup for the requested round index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cki_out <= 32'd0;
        end else begin
            cki_out <= ck_word(count);
        end
    end

endmodule

// File: rtl/sm4_sbox.sv
// SM4 byte substitution box, purely combinational lookup.
module sm4_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/sm4_tprime.sv
// SM4 key-schedule transform T'(x) = L'(tau(x)), L'(b) = b ^ (b <<< 13) ^ (b <<< 23).
module sm4_tprime
    import sm4_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    logic [31:0] b_s;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_i  (x_i[8*g +: 8]),
            .out_o (b_s[8*g +: 8])
        );
    end

    assign y_o = b_s ^ rotl32(b_s, 5'd13) ^ rotl32(b_s, 5'd23);

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key-expansion sequencer: one round key per cycle, optional 32x32 round-key file.
module sm4_key_expand
    import sm4_pkg::*;
#(
    parameter bit STORE_KEYS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] mkey,
    output logic         rk_valid,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         keys_ok,
    input  logic [4:0]   rd_addr,
    input  logic         rd_dec,
    output logic [31:0]  rd_data
);

    state_e            state_q, state_d;
    logic [3:0][31:0]  k_q, k_d;          // k_q[0] = K0 ... k_q[3] = K3
    logic [4:0]        round_q, round_d;
    logic              rk_valid_q, rk_valid_d;
    logic [31:0]       rk_out_q, rk_out_d;
    logic [4:0]        rk_idx_q, rk_idx_d;
    logic              done_q, done_d;
    logic              keys_ok_q, keys_ok_d;
    logic [31:0]       rd_data_q;

    logic [4:0]        ck_cnt_s;
    logic [31:0]       cki_s;
    logic [31:0]       t_in_s;
    logic [31:0]       t_out_s;
    logic [31:0]       rk_s;
    logic              wr_en_s;

    // The ROM is addressed one round ahead so CK[r] is already registered in round r.
    ck u_ck (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (ck_cnt_s),
        .cki_out (cki_s)
    );

    assign t_in_s = k_q[1] ^ k_q[2] ^ k_q[3] ^ cki_s;

    sm4_tprime u_tprime (
        .x_i (t_in_s),
        .y_o (t_out_s)
    );

    assign rk_s = k_q[0] ^ t_out_s;

    // Next-state, key-shift and output-register logic of the IDLE/LOAD/RUN sequencer.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        round_d    = round_q;
        rk_valid_d = 1'b0;
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        done_d     = 1'b0;
        keys_ok_d  = keys_ok_q;
        ck_cnt_s   = 5'd0;
        wr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    k_d       = {mkey[31:0]   ^ FK3, mkey[63:32]  ^ FK2,
                                 mkey[95:64]  ^ FK1, mkey[127:96] ^ FK0};
                    keys_ok_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                round_d = 5'd0;
                state_d = RUN;
            end
            RUN: begin
                ck_cnt_s   = round_q + 5'd1;   // wraps to 0 in the last round, unused
                k_d        = {rk_s, k_q[3], k_q[2], k_q[1]};
                rk_out_d   = rk_s;
                rk_idx_d   = round_q;
                rk_valid_d = 1'b1;
                wr_en_s    = 1'b1;
                if (round_q == 5'(SM4_ROUNDS - 1)) begin
                    done_d    = 1'b1;
                    keys_ok_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    round_d   = round_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            round_q    <= 5'd0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= 32'd0;
            rk_idx_q   <= 5'd0;
            done_q     <= 1'b0;
            keys_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            round_q    <= round_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            done_q     <= done_d;
            keys_ok_q  <= keys_ok_d;
        end
    end

    if (STORE_KEYS) begin : g_file
        logic [31:0] file_q [SM4_ROUNDS];
        logic [4:0]  rd_idx_s;

        assign rd_idx_s = rd_dec ? (5'd31 - rd_addr) : rd_addr;

        // Round-key file write; contents are deliberately not reset (keys_ok qualifies them).
        always_ff @(posedge clk) begin
            if (wr_en_s) begin
                file_q[round_q] <= rk_s;
            end
        end

        // Registered read port; a same-cycle write to the read address returns the old value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= 32'd0;
            end else begin
                rd_data_q <= file_q[rd_idx_s];
            end
        end
    end else begin : g_nofile
        assign rd_data_q = 32'd0;
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_out    = rk_out_q;
    assign rk_idx    = rk_idx_q;
    assign done      = done_q;
    assign keys_ok   = keys_ok_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand against a textbook SM4 key-schedule model.
module tb_sm4_key_expand;

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [31:0]  STD_RK0 = 32'hf12186f9;
    localparam logic [31:0]  STD_RK31 = 32'h9124a012;

    localparam logic [7:0] SB [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] mkey;
    logic         rk_valid;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx;
    logic         busy;
    logic         done;
    logic         keys_ok;
    logic [4:0]   rd_addr;
    logic         rd_dec;
    logic [31:0]  rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [31:0] ref_rk  [32];
    logic [31:0] cap_rk  [32];
    logic [4:0]  cap_idx [32];
    logic        cap_done[32];
    logic        cap_ok  [32];
    logic        cap_rdy [32];
    logic [31:0] cap_rd  [32];
    int          cap_vld;
    int          cap_gap;

    sm4_key_expand #(.STORE_KEYS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .mkey      (mkey),
        .rk_valid  (rk_valid),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .busy      (busy),
        .done      (done),
        .keys_ok   (keys_ok),
        .rd_addr   (rd_addr),
        .rd_dec    (rd_dec),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63 - n -: 32];
    endfunction

    function automatic logic [31:0] tprime_ref(input logic [31:0] x);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = SB[x[8*j +: 8]];
        return b ^ rotl_ref(b, 13) ^ rotl_ref(b, 23);
    endfunction

    function automatic logic [31:0] ck_ref(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    task automatic compute_ref(input logic [127:0] mk);
        logic [31:0] k [36];
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            k[i + 4] = k[i] ^ tprime_ref(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck_ref(i));
            ref_rk[i] = k[i + 4];
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic offer_key(input logic [127:0] mk);
        int n;
        key_valid = 1'b1;
        mkey = mk;
        n = 0;
        while (key_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic capture_stream();
        cap_gap = 0;
        while (rk_valid !== 1'b1 && cap_gap < 8) begin
            @(negedge clk);
            cap_gap++;
        end
        cap_vld = 0;
        for (int i = 0; i < 32; i++) begin
            cap_rk[i]   = rk_out;
            cap_idx[i]  = rk_idx;
            cap_done[i] = done;
            cap_ok[i]   = keys_ok;
            cap_rdy[i]  = key_ready;
            if (rk_valid === 1'b1) cap_vld++;
            if (i < 31) @(negedge clk);
        end
    endtask

    task automatic read_file(input logic dec);
        rd_dec = dec;
        rd_addr = 5'd0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            cap_rd[a] = rd_data;
            rd_addr = 5'(a + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; mkey = '0; rd_addr = 5'd0; rd_dec = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rk_valid, rk_out, rk_idx, done, keys_ok, rd_data, busy} !== 72'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rk_valid=%b rk_out=%h rk_idx=%0d done=%b keys_ok=%b rd_data=%h busy=%b expected all 0",
                     rk_valid, rk_out, rk_idx, done, keys_ok, rd_data, busy);
        end
        n_cmp++;
        if (key_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_key_ready: got %b expected 1", key_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offer one key, capture its stream, compare against the model; ends in the rk31 cycle.
    task automatic test_expand(input logic [127:0] mk, input string tag);
        compute_ref(mk);
        offer_key(mk);
        n_cmp++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            n_err++; $display("FAIL %s load_busy: got busy=%b key_ready=%b expected 1/0", tag, busy, key_ready);
        end
        capture_stream();
        n_cmp++;
        if (cap_gap !== 2) begin
            n_err++; $display("FAIL %s latency: got %0d cycles after load expected 2", tag, cap_gap);
        end
        n_cmp++;
        if (cap_vld !== 32) begin
            n_err++; $display("FAIL %s valid_cycles: got %0d expected 32", tag, cap_vld);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (cap_rk[i] !== ref_rk[i] || cap_idx[i] !== 5'(i)) begin
                n_err++;
                $display("FAIL %s rk[%0d]: got %h idx %0d expected %h idx %0d", tag, i, cap_rk[i], cap_idx[i], ref_rk[i], i);
            end
            n_cmp++;
            if (cap_done[i] !== (i == 31) || cap_ok[i] !== (i == 31) || cap_rdy[i] !== (i == 31)) begin
                n_err++;
                $display("FAIL %s flags[%0d]: got done=%b keys_ok=%b key_ready=%b expected %0d for all",
                         tag, i, cap_done[i], cap_ok[i], cap_rdy[i], (i == 31));
            end
        end
    endtask

    task automatic test_standard();
        test_expand(STD_KEY, "std");
        n_cmp++;
        if (cap_rk[0] !== STD_RK0 || cap_rk[31] !== STD_RK31) begin
            n_err++; $display("FAIL std_vector: got rk0=%h rk31=%h expected %h %h", cap_rk[0], cap_rk[31], STD_RK0, STD_RK31);
        end
        @(negedge clk);
        n_cmp++;
        if (rk_valid !== 1'b0 || done !== 1'b0 || keys_ok !== 1'b1) begin
            n_err++; $display("FAIL std_after: got rk_valid=%b done=%b keys_ok=%b expected 0 0 1", rk_valid, done, keys_ok);
        end
    endtask

    task automatic test_reverse_read();
        compute_ref(STD_KEY);
        read_file(1'b1);
        n_cmp++;
        if (cap_rd[0] !== STD_RK31) begin
            n_err++; $display("FAIL rev_read0: got %h expected %h", cap_rd[0], STD_RK31);
        end
        for (int a = 0; a < 32; a++) begin
            n_cmp++;
            if (cap_rd[a] !== ref_rk[31 - a]) begin
                n_err++; $display("FAIL rev_read[%0d]: got %h expected %h", a, cap_rd[a], ref_rk[31 - a]);
            end
        end
        read_file(1'b0);
        n_cmp++;
        if (cap_rd[0] !== STD_RK0) begin
            n_err++; $display("FAIL fwd_read0: got %h expected %h", cap_rd[0], STD_RK0);
        end
        for (int a = 0; a < 32; a++) begin
            n_cmp++;
            if (cap_rd[a] !== ref_rk[a]) begin
                n_err++; $display("FAIL fwd_read[%0d]: got %h expected %h", a, cap_rd[a], ref_rk[a]);
            end
        end
    endtask

    task automatic test_busy_reject();
        compute_ref(STD_KEY);
        @(negedge clk);
        key_valid = 1'b1;
        mkey = STD_KEY;
        @(negedge clk);
        mkey = '0;                       // keep offering a different key throughout RUN
        capture_stream();
        n_cmp++;
        if (cap_gap !== 2 || cap_vld !== 32) begin
            n_err++; $display("FAIL busy_first_timing: got gap=%0d valid=%0d expected 2 32", cap_gap, cap_vld);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (cap_rk[i] !== ref_rk[i] || cap_rdy[i] !== (i == 31)) begin
                n_err++;
                $display("FAIL busy_rk[%0d]: got %h key_ready=%b expected %h key_ready=%0d", i, cap_rk[i], cap_rdy[i], ref_rk[i], (i == 31));
            end
        end
        @(negedge clk);                  // second key accepted at the edge ending the rk31 cycle
        key_valid = 1'b0;
        compute_ref(128'd0);
        capture_stream();
        n_cmp++;
        if (cap_gap !== 2 || cap_vld !== 32) begin
            n_err++; $display("FAIL busy_second_timing: got gap=%0d valid=%0d expected 2 32", cap_gap, cap_vld);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (cap_rk[i] !== ref_rk[i] || cap_idx[i] !== 5'(i)) begin
                n_err++; $display("FAIL busy_second_rk[%0d]: got %h expected %h", i, cap_rk[i], ref_rk[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        offer_key(STD_KEY);
        n = 0;
        while (!(rk_valid === 1'b1 && rk_idx === 5'd10) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (rk_idx !== 5'd10 || rk_valid !== 1'b1) begin
            n_err++; $display("FAIL midrun_reach: got rk_idx=%0d rk_valid=%b expected 10 1", rk_idx, rk_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rk_valid, rk_out, rk_idx, done, keys_ok, rd_data, busy} !== 72'd0 || key_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_async_reset: got rk_valid=%b rk_out=%h rk_idx=%0d keys_ok=%b busy=%b key_ready=%b expected zeros and key_ready 1",
                     rk_valid, rk_out, rk_idx, keys_ok, busy, key_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (key_ready !== 1'b1 || keys_ok !== 1'b0) begin
            n_err++; $display("FAIL midrun_release: got key_ready=%b keys_ok=%b expected 1 0", key_ready, keys_ok);
        end
        test_expand(STD_KEY, "reexp");
        n_cmp++;
        if (cap_rk[0] !== STD_RK0 || cap_rk[31] !== STD_RK31) begin
            n_err++; $display("FAIL reexp_vector: got rk0=%h rk31=%h expected %h %h", cap_rk[0], cap_rk[31], STD_RK0, STD_RK31);
        end
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        test_expand(128'd0, "zero");
        @(negedge clk);
        read_file(1'b0);
        for (int a = 0; a < 32; a++) begin
            n_cmp++;
            if (cap_rd[a] !== ref_rk[a]) begin
                n_err++; $display("FAIL zero_file[%0d]: got %h expected %h", a, cap_rd[a], ref_rk[a]);
            end
        end
    endtask

    task automatic test_random_sweep();
        int base;
        int accepted;
        logic dec;
        logic [127:0] mk;
        base = done_cnt;
        accepted = 0;
        for (int k = 0; k < 200; k++) begin
            mk = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_expand(mk, "rand");
            accepted++;
            dec = 1'($urandom_range(0, 1));
            read_file(dec);
            for (int a = 0; a < 32; a++) begin
                n_cmp++;
                if (cap_rd[a] !== (dec ? ref_rk[31 - a] : ref_rk[a])) begin
                    n_err++;
                    $display("FAIL rand_file key%0d dec=%b addr %0d: got %h expected %h", k, dec, a, cap_rd[a],
                             dec ? ref_rk[31 - a] : ref_rk[a]);
                end
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt - base !== accepted) begin
            n_err++; $display("FAIL rand_done_count: got %0d expected %0d", done_cnt - base, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_reverse_read();
        test_busy_reject();
        test_reset_mid_run();
        test_all_zero();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
